// File: rtl/ula_arb_pkg.sv
// Shared definitions for the ula_arbiter slice: ALU op encoding, arbiter FSM states
// and the carry/borrow helper used by the optional flag outputs.
package ula_arb_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    // Carry-out of the 9-bit sum for ADD, unsigned borrow for SUB, 0 for logic ops.
    function automatic logic op_carry(input logic [7:0] a, input logic [7:0] b,
                                      input logic [1:0] op);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        case (op)
            OP_ADD:  return sum[8];
            OP_SUB:  return (a < b);
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr, wrapping
// from NREQ-1 to 0. Produces a one-hot grant, its index and an any-request flag.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [PW-1:0]   gnt_idx,
    output logic            any
);

    logic [2*NREQ-1:0] req_dbl;
    logic [NREQ-1:0]   rot;
    logic [PW-1:0]     off;
    logic [PW:0]       idx_sum;

    // Rotating the doubled vector puts requester ptr at bit 0 of rot.
    assign req_dbl = {req, req};
    assign rot     = NREQ'(req_dbl >> ptr);

    always_comb begin
        off = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                off = PW'(k);
            end
        end
    end

    always_comb begin
        idx_sum = {1'b0, ptr} + {1'b0, off};
        if (idx_sum >= (PW + 1)'(NREQ)) begin
            idx_sum = idx_sum - (PW + 1)'(NREQ);
        end
    end

    assign any     = |req;
    assign gnt_idx = idx_sum[PW-1:0];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_gnt
        assign gnt[gi] = any && (gnt_idx == PW'(gi));
    end

endmodule

// File: rtl/ula.sv
// Shared 8-bit ALU: ADD, SUB (a-b), AND, OR; arithmetic wraps modulo 256.
module ula
    import ula_arb_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [1:0] op,
    output logic [7:0] y
);

    always_comb begin
        y = 8'h00;
        case (op)
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            default: y = 8'h00;
        endcase
    end

endmodule

// File: rtl/ula_arbiter.sv
// Round-robin front end sharing one ula between NREQ requesters (grant, EXEC, RESP).
// Define ULA_ARB_FLAGS_EN to add registered resp_zero / resp_carry outputs.
module ula_arbiter
    import ula_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*8-1:0] req_a,
    input  logic [NREQ*8-1:0] req_b,
    input  logic [NREQ*2-1:0] req_op,
    output logic              resp_valid,
    output logic [IDW-1:0]    resp_id,
    output logic [7:0]        resp_result,
`ifdef ULA_ARB_FLAGS_EN
    output logic              resp_zero,
    output logic              resp_carry,
`endif
    output logic              busy
);

    localparam int PW = $clog2(NREQ);

    arb_state_t      state_reg, state_next;
    logic [PW-1:0]   ptr_reg, ptr_next;
    logic [7:0]      a_reg, b_reg;
    logic [1:0]      op_reg;
    logic [IDW-1:0]  id_reg;
    logic [7:0]      result_reg;

    logic [7:0]      a_arr  [NREQ];
    logic [7:0]      b_arr  [NREQ];
    logic [1:0]      op_arr [NREQ];

    logic [NREQ-1:0] gnt;
    logic [PW-1:0]   gnt_idx;
    logic            any;
    logic            grant;
    logic [7:0]      ula_y;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign a_arr[gi]  = req_a[gi*8 +: 8];
        assign b_arr[gi]  = req_b[gi*8 +: 8];
        assign op_arr[gi] = req_op[gi*2 +: 2];
    end

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr (
        .req     (req_valid),
        .ptr     (ptr_reg),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

    ula u_ula (
        .a  (a_reg),
        .b  (b_reg),
        .op (op_reg),
        .y  (ula_y)
    );

    // A transfer only happens in IDLE and never while reset is being applied.
    assign grant = (state_reg == IDLE) && any && !rst;

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        case (state_reg)
            IDLE: begin
                if (any) begin
                    state_next = EXEC;
                    ptr_next   = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
                end
            end
            EXEC:    state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg      <= '0;
            b_reg      <= '0;
            op_reg     <= '0;
            id_reg     <= '0;
            result_reg <= '0;
        end else begin
            if (grant) begin
                a_reg  <= a_arr[gnt_idx];
                b_reg  <= b_arr[gnt_idx];
                op_reg <= op_arr[gnt_idx];
                id_reg <= IDW'(gnt_idx);
            end
            if (state_reg == EXEC) begin
                result_reg <= ula_y;
            end
        end
    end

`ifdef ULA_ARB_FLAGS_EN
    logic zero_reg, carry_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            zero_reg  <= 1'b0;
            carry_reg <= 1'b0;
        end else if (state_reg == EXEC) begin
            zero_reg  <= (ula_y == 8'h00);
            carry_reg <= op_carry(a_reg, b_reg, op_reg);
        end
    end

    assign resp_zero  = zero_reg;
    assign resp_carry = carry_reg;
`endif

    assign req_ready   = grant ? gnt : '0;
    assign resp_valid  = (state_reg == RESP) && !rst;
    assign resp_id     = id_reg;
    assign resp_result = result_reg;
    assign busy        = (state_reg != IDLE);

endmodule

// File: tb/tb_ula_arbiter.sv
// Randomized self-checking bench for ula_arbiter against a cycle-count reference model.
module tb_ula_arbiter;

    localparam int N   = 4;
    localparam int IDW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [N-1:0]     v;
    logic [N-1:0]     req_ready;
    logic [7:0]       av  [N];
    logic [7:0]       bv  [N];
    logic [1:0]       opv [N];
    logic [N*8-1:0]   req_a, req_b;
    logic [N*2-1:0]   req_op;
    logic             resp_valid;
    logic [IDW-1:0]   resp_id;
    logic [7:0]       resp_result;
    logic             busy;
`ifdef ULA_ARB_FLAGS_EN
    logic             resp_zero, resp_carry;
`endif

    always_comb begin
        req_a  = '0;
        req_b  = '0;
        req_op = '0;
        for (int i = 0; i < N; i++) begin
            req_a[i*8 +: 8]  = av[i];
            req_b[i*8 +: 8]  = bv[i];
            req_op[i*2 +: 2] = opv[i];
        end
    end

    ula_arbiter #(.NREQ(N), .IDW(IDW)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (v),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_op      (req_op),
        .resp_valid  (resp_valid),
        .resp_id     (resp_id),
        .resp_result (resp_result),
`ifdef ULA_ARB_FLAGS_EN
        .resp_zero   (resp_zero),
        .resp_carry  (resp_carry),
`endif
        .busy        (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: timing from the cycle index of the last grant.
    int cyc        = 0;
    int last_grant = -100;
    int ptr        = 0;
    int exp_id     = 0;
    int exp_res    = 0;
    int exp_z      = 0;
    int exp_c      = 0;
    bit hold       = 1'b0;
    int obs [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int model_alu(input int a, input int b, input int op);
        case (op)
            0:       return (a + b) % 256;
            1:       return (a - b + 256) % 256;
            2:       return a & b;
            default: return a | b;
        endcase
    endfunction

    function automatic int model_carry(input int a, input int b, input int op);
        case (op)
            0:       return (a + b > 255) ? 1 : 0;
            1:       return (a < b) ? 1 : 0;
            default: return 0;
        endcase
    endfunction

    // Called just after a negedge with inputs already set; returns at the next negedge.
    task automatic tick();
        int g;
        bit idle;
        logic [N-1:0] er;
        #1;
        idle = (cyc >= last_grant + 3);
        g = -1;
        if (idle) begin
            for (int k = 0; k < N; k++) begin
                int j;
                j = (ptr + k) % N;
                if (v[j] && g < 0) g = j;
            end
        end
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        check("req_ready", 32'(req_ready), 32'(er));
        check("busy", 32'(busy), 32'(!idle));
        check("resp_valid", 32'(resp_valid), 32'(cyc == last_grant + 2));
        if (cyc == last_grant + 2) begin
            check("resp_id", 32'(resp_id), 32'(exp_id));
            check("resp_result", 32'(resp_result), 32'(exp_res));
`ifdef ULA_ARB_FLAGS_EN
            check("resp_zero", 32'(resp_zero), 32'(exp_z));
            check("resp_carry", 32'(resp_carry), 32'(exp_c));
`endif
            $display("resp cycle=%0d id=%0d result=%02h (exp id=%0d res=%02h z=%0d c=%0d)",
                     cyc, resp_id, resp_result, exp_id, exp_res, exp_z, exp_c);
        end
        for (int k = 0; k < N; k++) begin
            if (req_ready[k]) obs.push_back(k);
        end
        if (g >= 0) begin
            last_grant = cyc;
            ptr        = (g + 1) % N;
            exp_id     = g;
            exp_res    = model_alu(int'(av[g]), int'(bv[g]), int'(opv[g]));
            exp_z      = (exp_res == 0) ? 1 : 0;
            exp_c      = model_carry(int'(av[g]), int'(bv[g]), int'(opv[g]));
        end
        @(negedge clk);
        cyc++;
        if (g >= 0 && !hold) v[g] = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_ready", 32'(req_ready), 32'(0));
        @(negedge clk);
        v   = '0;
        rst = 1'b0;
        #1;
        check("rst_resp_valid", 32'(resp_valid), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_req_ready", 32'(req_ready), 32'(0));
        check("rst_resp_id", 32'(resp_id), 32'(0));
        check("rst_resp_result", 32'(resp_result), 32'(0));
`ifdef ULA_ARB_FLAGS_EN
        check("rst_resp_zero", 32'(resp_zero), 32'(0));
        check("rst_resp_carry", 32'(resp_carry), 32'(0));
`endif
        last_grant = -100;
        ptr        = 0;
        cyc++;
    endtask

    task automatic drain();
        v = '0;
        for (int k = 0; k < 4; k++) tick();
    endtask

    task automatic run_op(input int i, input logic [7:0] a, input logic [7:0] b,
                          input logic [1:0] op, input logic [7:0] res, input int z, input int c);
        v[i]   = 1'b1;
        av[i]  = a;
        bv[i]  = b;
        opv[i] = op;
        tick();
        tick();
        #1;
        check("op_valid", 32'(resp_valid), 32'(1));
        check("op_id", 32'(resp_id), 32'(i));
        check("op_result", 32'(resp_result), 32'(res));
`ifdef ULA_ARB_FLAGS_EN
        check("op_zero", 32'(resp_zero), 32'(z));
        check("op_carry", 32'(resp_carry), 32'(c));
`endif
        $display("op req=%0d a=%02h b=%02h op=%0d -> %02h (exp %02h z=%0d c=%0d)",
                 i, a, b, op, resp_result, res, z, c);
        tick();
    endtask

    initial begin
        int p0;
        rst = 1'b1;
        v   = '1;
        for (int i = 0; i < N; i++) begin
            av[i] = 8'h00; bv[i] = 8'h00; opv[i] = 2'b00;
        end
        repeat (2) @(negedge clk);
        do_reset();

        run_op(0, 8'h05, 8'h03, 2'b00, 8'h08, 0, 0);
        run_op(1, 8'hFF, 8'h01, 2'b00, 8'h00, 1, 1);
        run_op(2, 8'h02, 8'h05, 2'b01, 8'hFD, 0, 1);
        run_op(3, 8'hF0, 8'h3C, 2'b10, 8'h30, 0, 0);
        run_op(0, 8'hF0, 8'h0F, 2'b11, 8'hFF, 0, 0);

        // Fairness: all requesters held valid continuously.
        obs.delete();
        p0   = ptr;
        hold = 1'b1;
        v    = '1;
        for (int i = 0; i < N; i++) begin
            av[i] = 8'(8'h10 * (i + 1)); bv[i] = 8'(i + 1); opv[i] = 2'(i);
        end
        repeat (24) tick();
        hold = 1'b0;
        drain();
        check("fair_count", 32'(obs.size()), 32'(8));
        for (int k = 0; k < 8 && k < obs.size(); k++) begin
            check("fair_order", 32'(obs[k]), 32'((p0 + k) % N));
        end

        // Pointer and stability: grant 2, then 1 and 3 wait with changing operands.
        obs.delete();
        v[2] = 1'b1; av[2] = 8'h11; bv[2] = 8'h22; opv[2] = 2'b00;
        tick();
        v[1] = 1'b1; av[1] = 8'h40; bv[1] = 8'h01; opv[1] = 2'b01;
        v[3] = 1'b1; av[3] = 8'h0C; bv[3] = 8'h0A; opv[3] = 2'b10;
        tick();
        av[1] = 8'h90; av[3] = 8'h0F;
        tick();
        for (int k = 0; k < 4; k++) begin
            av[1] = av[1] + 8'h07;
            tick();
        end
        drain();
        check("ptr_count", 32'(obs.size()), 32'(3));
        if (obs.size() >= 3) begin
            check("ptr_first", 32'(obs[1]), 32'(3));
            check("ptr_second", 32'(obs[2]), 32'(1));
        end

        // Reset during EXEC: operation dropped, pointer back to 0.
        v[1] = 1'b1; av[1] = 8'h33; bv[1] = 8'h11; opv[1] = 2'b00;
        tick();
        do_reset();
        obs.delete();
        v[1] = 1'b1; av[1] = 8'h21; bv[1] = 8'h12; opv[1] = 2'b00;
        v[3] = 1'b1; av[3] = 8'h09; bv[3] = 8'h04; opv[3] = 2'b01;
        repeat (6) tick();
        drain();
        check("post_rst_first", 32'((obs.size() > 0) ? obs[0] : -1), 32'(1));

        // Randomized traffic.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!v[i] && $urandom_range(0, 3) == 0) begin
                    v[i]   = 1'b1;
                    av[i]  = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
                    bv[i]  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
                    opv[i] = 2'($urandom);
                end else if (v[i] && $urandom_range(0, 3) == 0) begin
                    av[i] = 8'($urandom);
                    bv[i] = 8'($urandom);
                end
            end
            tick();
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
